face_coords_tx: RTL



---
 rtl/face_coords_tx.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/face_coords_tx.sv
// Detection return path: FIFO-buffers face detections and sends each one as a
// 7-byte 8N1 UART frame (A5, pyramid, row hi/lo, col hi/lo, xor checksum).
module face_coords_tx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [1:0][31:0] face_coords,
    input  logic             face_coords_ready,
    input  logic [3:0]       pyramid_number,
    output logic             tx,
    output logic             tx_busy,
    output logic             fifo_full,
    output logic [15:0]      dropped_count
);

    localparam int unsigned AddrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] BaudMax = CntW'(CLKS_PER_BIT - 1);
    localparam logic [AddrW:0]  Depth   = (AddrW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {StIdle, StLoad, StStart, StData, StStop} state_e;

    state_e            state_q, state_d;
    logic [35:0]       mem_q [FIFO_DEPTH];
    logic [AddrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [AddrW:0]    count_q;
    logic [15:0]       dropped_q;
    logic [CntW-1:0]   baud_q;
    logic [2:0]        bit_idx_q, byte_idx_q;
    logic [35:0]       frame_q;
    logic [7:0]        cur_byte;
    logic              push, pop, drop, baud_done;
    logic              unused_upper;

    // Only the low 16 bits of row/col are meaningful for pyramid image sizes.
    assign unused_upper = ^{face_coords[0][31:16], face_coords[1][31:16]};

    assign drop      = face_coords_ready && (count_q == Depth);
    assign push      = face_coords_ready && !drop;
    assign pop       = (state_q == StLoad);
    assign baud_done = (baud_q == BaudMax);

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {pyramid_number, face_coords[0][15:0], face_coords[1][15:0]};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            dropped_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AddrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AddrW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (AddrW + 1)'(1);
                2'b01:   count_q <= count_q - (AddrW + 1)'(1);
                default: count_q <= count_q;
            endcase
            if (drop && (dropped_q != 16'hFFFF)) dropped_q <= dropped_q + 16'd1;
        end
    end

    // FSM state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= StIdle;
        else          state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (count_q != '0) state_d = StLoad;
            StLoad:  state_d = StStart;
            StStart: if (baud_done) state_d = StData;
            StData:  if (baud_done && (bit_idx_q == 3'd7)) state_d = StStop;
            StStop:  if (baud_done) state_d = (byte_idx_q == 3'd6) ? StIdle : StStart;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            baud_q     <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            frame_q    <= '0;
        end else begin
            if ((state_q != state_d) || baud_done) begin
                baud_q <= '0;
            end else if (state_q inside {StStart, StData, StStop}) begin
                baud_q <= baud_q + CntW'(1);
            end
            if (state_q == StStart) begin
                bit_idx_q <= '0;
            end else if ((state_q == StData) && baud_done) begin
                bit_idx_q <= bit_idx_q + 3'd1;
            end
            if (state_q == StLoad) begin
                frame_q    <= mem_q[rd_ptr_q];
                byte_idx_q <= '0;
            end else if ((state_q == StStop) && baud_done && (byte_idx_q != 3'd6)) begin
                byte_idx_q <= byte_idx_q + 3'd1;
            end
        end
    end

    // frame_q layout: [35:32] pyramid, [31:16] row, [15:0] col
    always_comb begin
        cur_byte = 8'hA5;
        case (byte_idx_q)
            3'd0:    cur_byte = 8'hA5;
            3'd1:    cur_byte = {4'h0, frame_q[35:32]};
            3'd2:    cur_byte = frame_q[31:24];
            3'd3:    cur_byte = frame_q[23:16];
            3'd4:    cur_byte = frame_q[15:8];
            3'd5:    cur_byte = frame_q[7:0];
            3'd6:    cur_byte = {4'h0, frame_q[35:32]} ^ frame_q[31:24] ^ frame_q[23:16]
                                ^ frame_q[15:8] ^ frame_q[7:0];
            default: cur_byte = 8'hA5;
        endcase
    end

    // FSM output logic
    always_comb begin
        tx = 1'b1;
        unique case (state_q)
            StStart: tx = 1'b0;
            StData:  tx = cur_byte[bit_idx_q];
            default: tx = 1'b1;
        endcase
    end

    assign tx_busy       = (count_q != '0) || (state_q != StIdle);
    assign fifo_full     = (count_q == Depth);
    assign dropped_count = dropped_q;

endmodule
